lsu: RTL

Load/store unit between the core's data-access request and the data port (port 2) of the byte-addressed unified RAM. The RAM port reads a little-endian 32-bit word combinationally and writes a full 32-bit word on the clock edge. This block converts core requests into whole-word RAM traffic:
- byte and halfword loads: lane extraction plus sign- or zero-extension;
- byte and halfword stores: read-modify-write;
- misaligned or out-of-range requests: rejected without touching memory.

---
 rtl/lsu_if.sv | 28 ++
 rtl/lsu.sv | 136 +++++++++++++
 2 files changed

// File: rtl/lsu_if.sv
// Core request/response and RAM port-2 signals of the load/store unit.
// slave is the LSU side; master is the core/RAM side.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd;
  logic        mem_we;
  logic [31:0] mem_wd;

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_wd
  );

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_wd
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: turns byte/half/word core accesses into whole-word RAM traffic,
// with lane extraction on loads and read-modify-write on sub-word stores.
module lsu #(
  parameter int unsigned MEM_SIZE = 4096
) (
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StLoad, StMerge, StWrite, StResp} state_e;

  localparam logic [32:0] MemLast = 33'(MEM_SIZE) - 33'd1;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] waddr;
  logic [32:0] req_last;
  logic        req_err;
  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign waddr    = {addr_q[31:2], 2'b00};
  // 33-bit sum so addresses near 0xFFFFFFFF cannot wrap into range.
  assign req_last = {1'b0, bus.req_addr[31:2], 2'b00} + 33'd3;

  always_comb begin
    req_err = 1'b0;
    if (bus.req_size[1:0] == 2'b11) begin
      req_err = 1'b1;
    end else if (bus.req_size[1:0] == 2'b01 && bus.req_addr[0]) begin
      req_err = 1'b1;
    end else if (bus.req_size[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) begin
      req_err = 1'b1;
    end else if (req_last > MemLast) begin
      req_err = 1'b1;
    end
  end

  always_comb begin
    unique case (addr_q[1:0])
      2'd0:    lane8 = bus.mem_rd[7:0];
      2'd1:    lane8 = bus.mem_rd[15:8];
      2'd2:    lane8 = bus.mem_rd[23:16];
      default: lane8 = bus.mem_rd[31:24];
    endcase
    lane16 = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
    unique case (size_q[1:0])
      2'b00:   load_val = size_q[2] ? {24'd0, lane8} : {{24{lane8[7]}}, lane8};
      2'b01:   load_val = size_q[2] ? {16'd0, lane16} : {{16{lane16[15]}}, lane16};
      default: load_val = bus.mem_rd;
    endcase
  end

  always_comb begin
    merge_val = bus.mem_rd;
    if (size_q[1:0] == 2'b00) begin
      unique case (addr_q[1:0])
        2'd0:    merge_val[7:0]   = wdata_q[7:0];
        2'd1:    merge_val[15:8]  = wdata_q[7:0];
        2'd2:    merge_val[23:16] = wdata_q[7:0];
        default: merge_val[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_val[31:16] = wdata_q[15:0];
    end else begin
      merge_val[15:0] = wdata_q[15:0];
    end
  end

  // wdata_q doubles as the write-data register: MERGE overwrites it with the merged word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            size_q  <= bus.req_size;
            wdata_q <= bus.req_wdata;
            if (req_err) begin
              err_q   <= 1'b1;
              state_q <= StResp;
            end else if (!bus.req_we) begin
              state_q <= StLoad;
            end else if (bus.req_size[1:0] == 2'b10) begin
              state_q <= StWrite;
            end else begin
              state_q <= StMerge;
            end
          end
        end
        StLoad: begin
          rdata_q <= load_val;
          state_q <= StResp;
        end
        StMerge: begin
          wdata_q <= merge_val;
          state_q <= StWrite;
        end
        StWrite: state_q <= StResp;
        StResp: begin
          if (bus.rsp_ready) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_we    = (state_q == StWrite);
  assign bus.mem_wd    = wdata_q;
  assign bus.mem_addr  = (state_q == StLoad || state_q == StMerge || state_q == StWrite) ?
                         waddr : 32'd0;

endmodule
